gray_to_binary_decoder: RTL and testbench
=========================================

GRAY_TO_BINARY_DECODER -- requirements
Module: gray_to_binary_decoder

Interface
REQ-001 SHALL have parameter: WIDTH, 4, code width in bits (legal range 2..16).
REQ-002 SHALL have parameter: CNT_W, 8, width of error counter.
REQ-003 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: in_valid  input  1  in_gray holds a word.
REQ-006 SHALL have port: in_ready  output  1  block accepts the word this cycle.
REQ-007 SHALL have port: in_gray  input  WIDTH  Gray-coded word.
REQ-008 SHALL have port: out_valid  output  1  out_* fields hold a word.
REQ-009 SHALL have port: out_ready  input  1  sink accepts the output word this cycle.
REQ-010 SHALL have port: out_bin  output  WIDTH  decoded binary value.
REQ-011 SHALL have port: out_dir  output  1  1 = step up (+1 mod 2^WIDTH), 0 = any other step.
REQ-012 SHALL have port: step_err  output  1  word differs from the previous accepted word in other than exactly one bit.
REQ-013 SHALL have port: err_cnt  output  CNT_W  saturating count of step errors.

Function
REQ-014 SHALL decode as out_bin[WIDTH-1] = g[WIDTH-1] and out_bin[i] = out_bin[i+1] XOR g[i] for i = WIDTH-2 down to 0.
REQ-015 SHALL accept a word when in_valid && in_ready, and SHALL drive in_ready = !out_valid || out_ready.
REQ-016 SHALL present the accepted word's out_bin, out_dir and step_err, registered, with out_valid high on the next clock edge (latency 1).
REQ-017 SHALL hold out_* stable while out_valid && !out_ready, and SHALL clear out_valid after out_ready with no new accept.
REQ-018 SHALL sustain one word per cycle when out_ready is held high (simultaneous accept and drain).
REQ-019 SHALL keep the previous accepted Gray word in a register; the first word after reset SHALL be unchecked (step_err=0, out_dir=0).
REQ-020 SHALL set step_err when popcount(in_gray XOR prev) != 1, including the repeat of an identical word.
REQ-021 SHALL set out_dir=1 only when new binary == previous binary + 1 mod 2^WIDTH; wrap-around from all-ones to zero counts as up.
REQ-022 SHALL increment err_cnt by 1 on each accepted word with step_err=1, saturating at 2^CNT_W-1.
REQ-023 SHALL update the previous-word register on every accept, including erroneous words.

Reset
REQ-024 SHALL, while rst is high, asynchronously force out_valid=0, out_bin=0, out_dir=0, step_err=0, err_cnt=0, and the first-word flag set, so that in_ready=1 at the next clock after release.
REQ-025 SHALL, on reset mid-stream, discard any held output word; the first word after release SHALL be unchecked.

Configuration
REQ-026 SHALL, with GRAY_STEP_CHECK_EN defined, implement REQ-019..REQ-023 in full.
REQ-027 SHALL, without GRAY_STEP_CHECK_EN, tie step_err=0, out_dir=0 and err_cnt=0, omit the previous-word register, and leave the decode and handshake unchanged.

Structure
REQ-028 SHALL take no shared package; WIDTH and CNT_W stay local parameters.
REQ-029 SHALL place the combinational decode in the sub-module gray_to_bin_comb (WIDTH parameter, in gray, out bin), reusable by other blocks.

Verification (WIDTH=4, macro defined unless stated)
REQ-030 SHALL cover a full sweep: out_ready=1, gray 0000,0001,0011,0010,0110,...,1000 one per cycle -> out_bin 0..15, each one cycle after its input; out_dir=1 from the second word on; step_err=0.
REQ-031 SHALL cover wrap-around: gray 1000 then 0000 -> out_bin 15 then 0, out_dir=1, step_err=0.
REQ-032 SHALL cover bad steps: gray 0001 then 0010, then 0010 repeated -> out_bin 1,3,3 with step_err=0,1,1 and err_cnt ending at 2.
REQ-033 SHALL cover backpressure: out_ready=0 with 0110 accepted -> out_bin=4 held, in_ready=0; then out_ready=1 with in 0111 in the same cycle -> out_bin=5 on the next cycle.
REQ-034 SHALL cover reset mid-stream: rst pulse while out_valid=1 -> out_valid=0 and err_cnt=0 immediately; next word 1111 -> out_bin=10, step_err=0.
REQ-035 SHALL cover the macro undefined: rerun REQ-032 -> same out_bin, step_err=0 and err_cnt=0 throughout.

Source files
------------

// File: rtl/gray_to_bin_comb.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
// Stateless and parameterised so other blocks can reuse it directly.
module gray_to_bin_comb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Running XOR from the MSB down; acc keeps the loop free of self-reads on bin.
  always_comb begin
    logic acc;
    acc = 1'b0;
    bin = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/gray_to_binary_decoder.sv
// Registered Gray-to-binary decoder with valid/ready handshake (latency 1, one word per cycle).
// Define GRAY_STEP_CHECK_EN to enable step checking, direction flag and the saturating error counter.
module gray_to_binary_decoder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_dir,
  output logic             step_err,
  output logic [CNT_W-1:0] err_cnt
);

  logic             accept;
  logic [WIDTH-1:0] dec_bin;

  gray_to_bin_comb #(.WIDTH(WIDTH)) u_dec (
    .gray (in_gray),
    .bin  (dec_bin)
  );

  // Output slot is free when empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Output slot: load on accept, drop valid on drain without a replacement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bin   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_bin   <= dec_bin;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic             first_q;
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] diff_c;
  logic             one_bit_c;
  logic             up_c;
  logic             bad_c;

  // A legal step flips exactly one bit; up means binary advanced by one, wrapping.
  always_comb begin
    diff_c    = in_gray ^ prev_gray;
    one_bit_c = (diff_c != '0) && ((diff_c & (diff_c - WIDTH'(1))) == '0);
    up_c      = (dec_bin == (prev_bin + WIDTH'(1)));
    bad_c     = !first_q && !one_bit_c;
  end

  // History and flags advance on every accept, erroneous words included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q   <= 1'b1;
      prev_gray <= '0;
      prev_bin  <= '0;
      out_dir   <= 1'b0;
      step_err  <= 1'b0;
      err_cnt   <= '0;
    end else if (accept) begin
      first_q   <= 1'b0;
      prev_gray <= in_gray;
      prev_bin  <= dec_bin;
      step_err  <= bad_c;
      out_dir   <= !first_q && up_c;
      if (bad_c && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign out_dir  = 1'b0;
  assign step_err = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_gray_to_binary_decoder.sv
// Randomised + directed bench for gray_to_binary_decoder against a table-driven reference model.
// Follows GRAY_STEP_CHECK_EN to decide whether step checking is expected.
module tb_gray_to_binary_decoder;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;
`ifdef GRAY_STEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_gray;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bin;
  logic             out_dir;
  logic             step_err;
  logic [CNT_W-1:0] err_cnt;

  gray_to_binary_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gray   (in_gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_dir   (out_dir),
    .step_err  (step_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int   inv [16];
  bit   m_valid;
  int   m_bin;
  bit   m_dir;
  bit   m_err;
  int   m_cnt;
  int   m_prev_g;
  int   m_prev_bin;
  bit   m_first;
  logic [WIDTH-1:0] last_g;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_bin = 0; m_dir = 0; m_err = 0; m_cnt = 0;
    m_prev_g = 0; m_prev_bin = 0; m_first = 1;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".bin"},   32'(out_bin),   32'(m_bin));
    check({tag, ".dir"},   32'(out_dir),   32'(m_dir));
    check({tag, ".err"},   32'(step_err),  32'(m_err));
    check({tag, ".cnt"},   32'(err_cnt),   32'(m_cnt));
  endtask

  // One clock of stimulus; model advances from the spec's rules.
  task automatic drive(input string tag, input bit v, input logic [WIDTH-1:0] g, input bit r);
    bit acc;
    int n;
    in_valid  = v;
    in_gray   = g;
    out_ready = r;
    #1;
    acc = v && (!m_valid || r);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || r));
    @(posedge clk);
    #1;
    if (acc) begin
      n = inv[int'(g)];
      if (CHK && !m_first) begin
        m_err = ($countones(int'(g) ^ m_prev_g) != 1);
        m_dir = (n == ((m_prev_bin + 1) % 16));
        if (m_err && m_cnt < 255) m_cnt++;
      end else begin
        m_err = 0;
        m_dir = 0;
      end
      m_first    = 0;
      m_prev_g   = int'(g);
      m_prev_bin = n;
      m_valid    = 1;
      m_bin      = n;
      last_g     = g;
    end else if (r) begin
      m_valid = 0;
    end
    check_outs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_outs(tag);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < 16; n++) inv[n ^ (n >> 1)] = n;
    rst = 1'b1; in_valid = 1'b0; in_gray = '0; out_ready = 1'b0; last_g = '0;
    model_reset();
    #2;
    check_outs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full sweep at one word per cycle, then wrap 1000 -> 0000
    for (int n = 0; n < 16; n++) drive("sweep", 1'b1, 4'(n ^ (n >> 1)), 1'b1);
    drive("wrap", 1'b1, 4'b0000, 1'b1);
    drive("drain", 1'b0, 4'b0000, 1'b1);

    // Bad steps: two-bit change, then identical repeat
    drive("bad0", 1'b1, 4'b0001, 1'b1);
    drive("bad1", 1'b1, 4'b0010, 1'b1);
    drive("bad2", 1'b1, 4'b0010, 1'b1);
    drive("drain", 1'b0, 4'b0000, 1'b1);

    // Backpressure: hold 4, refuse 0111, then accept it as the slot drains
    drive("bp0", 1'b1, 4'b0110, 1'b0);
    drive("bp1", 1'b1, 4'b0111, 1'b0);
    drive("bp2", 1'b1, 4'b0111, 1'b1);
    drive("bp3", 1'b0, 4'b0000, 1'b1);

    // Reset with a held word, then first word is unchecked
    drive("pre_rst", 1'b1, 4'b0011, 1'b0);
    do_reset("mid_rst");
    drive("post_rst", 1'b1, 4'b1111, 1'b1);

    // Random traffic: mostly legal steps, some repeats and jumps
    for (int k = 0; k < 600; k++) begin
      int sel;
      logic [WIDTH-1:0] g;
      sel = int'($urandom_range(99));
      if (sel < 70)      g = last_g ^ 4'(1 << $urandom_range(3));
      else if (sel < 85) g = last_g;
      else               g = 4'($urandom);
      drive("rand", 1'($urandom_range(3) != 0), g, 1'($urandom_range(3) != 0));
    end

    // Repeats push the error counter to saturation
    for (int k = 0; k < 300; k++) drive("sat", 1'b1, last_g, 1'b1);
    drive("drain", 1'b0, 4'b0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
